// File: rtl/alu_multicycle_if.sv
// Operand/result bundle between the execute-stage core and alu_multicycle.
// Handshake: start is a request taken only at an edge where busy=0; done pulses
// for exactly one cycle when result/hi/zero are updated; start while busy=1 is dropped.
`timescale 1ns/1ps
interface alu_multicycle_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [3:0]       alucontrol;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    modport master (
        output start, alucontrol, sign, a, b, shamt,
        input  result, hi, zero, busy, done, dbg_state
    );

    modport slave (
        input  start, alucontrol, sign, a, b, shamt,
        output result, hi, zero, busy, done, dbg_state
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare ops plus an
// iterative shift-add multiplier producing a full 2*WIDTH product on {hi,result}.
`timescale 1ns/1ps
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    alu_multicycle_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1111;

    state_t               state_q, state_d;
    logic [SHW-1:0]       count_q, count_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 zero_q, zero_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     alu_res;
    logic                 slt_bit;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   prod;

    always_comb begin
        slt_bit = bus.sign ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);
        alu_res = '0;
        case (bus.alucontrol)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SLL:  alu_res = bus.b << bus.shamt;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            default: alu_res = '0;
        endcase
    end

    // Magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is correct read unsigned.
    always_comb begin
        a_mag = (bus.sign & bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (bus.sign & bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // One shift-add iteration: carry out of the upper-half add shifts back in at the top.
    always_comb begin
        step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
        prod     = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.alucontrol == OP_MUL) begin
                        mcand_d  = a_mag;
                        mplier_d = b_mag;
                        neg_d    = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc_d    = '0;
                        count_d  = '0;
                        busy_d   = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = {step_sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                count_d  = count_q + SHW'(1);
                if (count_q == SHW'(WIDTH-1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                result_d = prod[WIDTH-1:0];
                hi_d     = prod[2*WIDTH-1:WIDTH];
                zero_d   = (prod[WIDTH-1:0] == '0);
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.hi        = hi_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: single-cycle ops, MUL latency/values,
// ignored start while busy, back-to-back issue and asynchronous abort.
`timescale 1ns/1ps
module tb_alu_multicycle;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    int   edges, busy_n, n_done, n_busy;

    alu_multicycle_if #(.WIDTH(W), .SHW(5)) bus ();

    alu_multicycle #(.WIDTH(W), .SHW(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic sg, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh);
        bus.alucontrol = op;
        bus.sign       = sg;
        bus.a          = av;
        bus.b          = bv;
        bus.shamt      = sh;
        bus.start      = 1'b1;
    endtask

    // Presents an op for one edge; on return we sit just after the acceptance edge.
    task automatic issue(input logic [3:0] op, input logic sg, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh);
        drive(op, sg, av, bv, sh);
        tick;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.sign  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(inout int e, inout int bn);
        while (bus.done !== 1'b1 && e < 60) begin
            if (bus.busy === 1'b1) bn++;
            tick;
            e++;
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.alucontrol = 4'b0000;
        bus.sign       = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.shamt      = '0;
        repeat (3) tick;
        check("rst_result", bus.result, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_zero", bus.zero, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_state", bus.dbg_state, 0);
        reset_n = 1'b1;
        tick;

        // ADD 5+7
        issue(4'b0010, 1'b0, 32'd5, 32'd7, 5'd0);
        check("add_result", bus.result, 12);
        check("add_zero", bus.zero, 0);
        check("add_done", bus.done, 1);
        check("add_busy", bus.busy, 0);
        tick;
        check("add_done_drop", bus.done, 0);
        check("add_busy_after", bus.busy, 0);

        issue(4'b0110, 1'b0, 32'd3, 32'd3, 5'd0);
        check("sub_result", bus.result, 0);
        check("sub_zero", bus.zero, 1);
        tick;

        issue(4'b0111, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("slt_signed", bus.result, 1);
        tick;
        issue(4'b0111, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("slt_unsigned", bus.result, 0);
        check("slt_unsigned_zero", bus.zero, 1);

        // Back-to-back single-cycle ops with no idle cycle between them
        issue(4'b0000, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0);
        check("and_result", bus.result, 32'h00F0_000F);
        issue(4'b0001, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0);
        check("or_result", bus.result, 32'hFFF0_0FFF);
        check("or_done", bus.done, 1);
        issue(4'b1100, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0);
        check("nor_result", bus.result, 32'h000F_F000);
        check("nor_hi_kept", bus.hi, 0);
        issue(4'b0011, 1'b0, 32'h1234_5678, 32'd1, 5'd31);
        check("sll_result", bus.result, 32'h8000_0000);
        check("sll_zero", bus.zero, 0);
        issue(4'b0101, 1'b0, 32'd9, 32'd4, 5'd0);
        check("undef_result", bus.result, 0);
        check("undef_zero", bus.zero, 1);
        check("undef_done", bus.done, 1);
        tick;
        check("undef_done_drop", bus.done, 0);

        // Signed MUL -3 * 7
        issue(4'b1111, 1'b1, 32'hFFFF_FFFD, 32'd7, 5'd0);
        check("mul_s_busy_on", bus.busy, 1);
        check("mul_s_state", bus.dbg_state, 1);
        edges = 0; busy_n = 0;
        wait_done(edges, busy_n);
        check("mul_s_edges", 64'(edges), 33);
        check("mul_s_busy_cycles", 64'(busy_n), 33);
        check("mul_s_result", bus.result, 32'hFFFF_FFEB);
        check("mul_s_hi", bus.hi, 32'hFFFF_FFFF);
        check("mul_s_zero", bus.zero, 0);
        check("mul_s_busy_off", bus.busy, 0);
        tick;
        check("mul_s_done_drop", bus.done, 0);

        // Unsigned MUL 0xFFFFFFFF^2
        issue(4'b1111, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        edges = 0; busy_n = 0;
        wait_done(edges, busy_n);
        check("mul_u_edges", 64'(edges), 33);
        check("mul_u_result", bus.result, 32'h0000_0001);
        check("mul_u_hi", bus.hi, 32'hFFFF_FFFE);
        tick;

        // Abort a MUL with reset 15 cycles in
        issue(4'b1111, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd0);
        repeat (14) tick;
        reset_n = 1'b0;
        #1;
        check("abort_result", bus.result, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_zero", bus.zero, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        repeat (2) tick;
        reset_n = 1'b1;
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (bus.done === 1'b1) n_done++;
            if (bus.busy === 1'b1) n_busy++;
        end
        check("abort_no_done", 64'(n_done), 0);
        check("abort_no_busy", 64'(n_busy), 0);

        issue(4'b1111, 1'b0, 32'd6, 32'd7, 5'd0);
        edges = 0; busy_n = 0;
        wait_done(edges, busy_n);
        check("mul_67_result", bus.result, 42);
        check("mul_67_hi", bus.hi, 0);
        tick;

        // Signed edge case: -2^31 * -2^31 = 2^62
        issue(4'b1111, 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd0);
        edges = 0; busy_n = 0;
        wait_done(edges, busy_n);
        check("mul_min_result", bus.result, 0);
        check("mul_min_hi", bus.hi, 32'h4000_0000);
        check("mul_min_zero", bus.zero, 1);
        tick;

        // start while busy is ignored, then back-to-back ADD in the done cycle
        issue(4'b1111, 1'b0, 32'd1000, 32'd3, 5'd0);
        edges = 0; busy_n = 0;
        n_done = 0;
        for (int i = 0; i < 9; i++) begin
            tick;
            edges++;
            if (bus.done === 1'b1) n_done++;
        end
        drive(4'b0010, 1'b0, 32'd1, 32'd1, 5'd0);
        tick;
        edges++;
        if (bus.done === 1'b1) n_done++;
        bus.start = 1'b0;
        wait_done(edges, busy_n);
        check("ign_early_done", 64'(n_done), 0);
        check("ign_edges", 64'(edges), 33);
        check("ign_result", bus.result, 32'd3000);
        check("ign_hi", bus.hi, 0);
        issue(4'b0010, 1'b0, 32'd1, 32'd1, 5'd0);
        check("b2b_result", bus.result, 2);
        check("b2b_done", bus.done, 1);
        check("b2b_busy", bus.busy, 0);
        tick;
        check("b2b_done_drop", bus.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Execute-stage ALU; consumes the 4-bit alucontrol code and sign flag produced by the ALU control decoder, plus two operands and a shift amount.
- Logic, add/sub, shift and compare ops complete in 1 cycle.
- MUL runs an iterative shift-add multiplier over WIDTH cycles; the core stalls on busy and reads result on done.
- Full 2*WIDTH product: low half on result, high half on hi.

Parameters:
WIDTH, 32, operand/result width in bits (even, >= 8)
SHW, 5, shift-amount width; equals log2(WIDTH)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  operation request; sampled only when busy=0
alucontrol  input  4  operation code (encodings below)
sign  input  1  1 = signed SLT/MUL, 0 = unsigned
a  input  WIDTH  operand A
b  input  WIDTH  operand B
shamt  input  SHW  shift amount for SLL
result  output  WIDTH  registered result (low product half for MUL)
hi  output  WIDTH  high product half; updated only by MUL
zero  output  1  registered (result == 0)
busy  output  1  MUL in progress
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset_n=0, async): state=IDLE; result, hi, zero, busy, done all 0; counter and accumulators cleared. An in-flight MUL is aborted and produces no done.
- Op codes:
  - 0000 AND: a&b
  - 0001 OR: a|b
  - 0010 ADD: a+b mod 2^WIDTH, no overflow flag
  - 0011 SLL: b<<shamt
  - 0110 SUB: a-b mod 2^WIDTH
  - 0111 SLT: 1 if a<b (signed compare when sign=1, unsigned when sign=0), else 0
  - 1100 NOR: ~(a|b)
  - 1111 MUL: iterative
  - Any other code: result=0, completes as a 1-cycle op.
  - The decoder emits 0001 for OR; 0111 is SLT only.
- FSM states: IDLE, MUL, FIN.
- IDLE, start=1, non-MUL code at edge k: result and zero are written at edge k. done=1 for the cycle after edge k, then 0. busy stays 0. hi is unchanged.
- IDLE, start=1, MUL code at edge k:
  - Latch |a| and |b| (magnitudes when sign=1, raw values when sign=0).
  - Latch neg = sign & (a[msb] ^ b[msb]).
  - Clear the 2*WIDTH accumulator; count=0; busy=1; go to MUL.
- MUL state, each edge: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half; shift the accumulator right 1 with carry-in; count++. After WIDTH iterations (edge k+WIDTH), go to FIN.
- FIN state, edge k+WIDTH+1:
  - {hi,result} = neg ? two's-complement of the accumulator : accumulator.
  - zero = (result==0), low half only.
  - busy=0; done=1 for one cycle; go to IDLE.
- Total MUL latency: done is high in the cycle after edge k+WIDTH+1 (WIDTH+2 edges after acceptance).
- Operand inputs (a, b, sign, shamt) may change freely after acceptance; they are sampled only at acceptance.
- start while busy=1 is ignored: no queueing, no effect on the running op.
- start asserted in the cycle done=1 is accepted at the next edge, giving back-to-back ops.
- result, hi and zero hold their values until the next completion.
- Signed edge case: sign=1 with operand -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which is representable unsigned. The product is exact within 2*WIDTH bits.

Test Plan:
- ADD a=5, b=7, start one cycle -> result=12, zero=0, done high exactly one cycle after the start edge, busy never 1.
- SUB a=3, b=3 -> result=0, zero=1. SLT a=0xFFFFFFFF, b=1: sign=1 -> result=1; sign=0 -> result=0.
- MUL signed, a=-3, b=7 -> busy for 33 cycles, done at the 34th edge, result=0xFFFFFFEB, hi=0xFFFFFFFF. Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, result=0x00000001.
- During a MUL, pulse start with ADD a=1, b=1 at cycle 10 -> ignored; MUL result unchanged and only one done pulse. Then start ADD in the done cycle -> result=2 on the following cycle.
- Assert reset_n=0 mid-MUL at cycle 15 -> all outputs 0 immediately (async), no done. After release, a fresh MUL 6*7 with sign=0 -> result=42, hi=0.
- SLL b=1, shamt=31 -> result=0x80000000. Undefined code 0101 -> result=0, zero=1, done 1 cycle.
